instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Parametrised synchronous instruction memory for the RISC-V fetch stage. It replaces the asynchronous-read instruction store.
- Registered read with a valid/ready request and response handshake, and a one-deep output stage with backpressure.
- Alignment and range checking, with a fault flag on bad fetches.
- A program-load write port and a fetch flush for branch redirects.
- Sits between the PC/fetch unit and the decode stage.

Parameters:
- DATA_W, 32, instruction word width in bits. Fixed at 32 for RV32; the parameter exists only for checking.
- DEPTH, 4096, number of words. Must be a power of 2, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be DEPTH*4-aligned.
- NOP_INSTR, 32'h0000_0013, word returned on a faulted fetch (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, all logic on the rising edge
- rst_n_i  in  1  synchronous active-low reset
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  block can accept a request this cycle
- req_addr_i  in  32  fetch byte address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts the response
- rsp_instr_o  out  DATA_W  fetched instruction, or NOP_INSTR on fault
- rsp_addr_o  out  32  byte address that produced this response
- rsp_fault_o  out  1  response is a misaligned or out-of-range fetch
- flush_i  in  1  discard any pending or in-flight response
- wr_en_i  in  1  program-load write strobe
- wr_addr_i  in  32  program-load byte address
- wr_data_i  in  DATA_W  program-load data

Behaviour:
- Reset is synchronous and active-low. On the first rising edge with rst_n_i=0:
  - rsp_valid_o=0, rsp_fault_o=0, rsp_instr_o=0, rsp_addr_o=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation drops any held response on that edge.
- Index computation:
  - IDX_W = clog2(DEPTH).
  - off = req_addr_i - BASE_ADDR, computed in 32 bits with wrap-around.
  - idx = off[IDX_W+1:2].
- Fault rules:
  - Misaligned: req_addr_i[1:0] != 0.
  - Out of range: off >= DEPTH*4, compared unsigned. Addresses below BASE_ADDR wrap to large values and therefore fault.
  - fault = misaligned OR out_of_range.
- Request acceptance:
  - req_ready_o = !rsp_valid_o || rsp_ready_i. It is combinational, with no dependency on req_valid_i.
  - A request is accepted when req_valid_i && req_ready_o && !flush_i.
- Latency is exactly 1 cycle. A request accepted at edge N presents its response after edge N:
  - rsp_valid_o=1 and rsp_addr_o=req_addr_i.
  - rsp_instr_o = fault ? NOP_INSTR : mem[idx].
  - rsp_fault_o = fault.
- Backpressure:
  - While rsp_valid_o && !rsp_ready_i, every response output holds stable and req_ready_o=0.
  - On rsp_valid_o && rsp_ready_i with a new accepted request, the response is replaced the next cycle, giving back-to-back throughput of 1/cycle.
  - On rsp_valid_o && rsp_ready_i with no accepted request, rsp_valid_o goes to 0 the next cycle.
- Flush:
  - flush_i=1 forces rsp_valid_o=0 the next cycle.
  - The request offered in the same cycle is not accepted.
  - req_ready_o is not gated by flush_i.
  - Flush has priority over both accept and hold.
- Write port:
  - On wr_en_i, a write to mem[wr idx] occurs at the edge, where wr idx is computed from wr_addr_i exactly like the read index.
  - The write is dropped if wr_addr_i is misaligned or out of range. No error output.
  - Writes are independent of the handshake and permitted during reset.
- Read/write collision: on the same index in the same cycle, the read returns the OLD data (read-first). The new data is visible to requests accepted on later edges.
- A held response is never altered by a later write to its address.
- Memory is inferred as a single-port-read, single-port-write synchronous RAM with no reset on the array.

Test Plan:
- Load and read back:
  - Stimulus: reset, write 32'h0010_0093 @0x0 and 32'h0020_0113 @0x4; request 0x0 then 0x4 on consecutive cycles with rsp_ready_i=1.
  - Required: responses 0x00100093 then 0x00200113 on cycles N+1 and N+2, fault=0, rsp_addr_o 0x0/0x4.
- Backpressure hold:
  - Stimulus: request 0x4, hold rsp_ready_i=0 for 3 cycles.
  - Required: rsp_valid_o=1 and instr 0x00200113 stable, req_ready_o=0 throughout; release, then next request accepted the following cycle.
- Faults:
  - Stimulus: request 0x2; request DEPTH*4 (0x4000); with BASE_ADDR=0x8000_0000, request 0x0.
  - Required: each gives rsp_fault_o=1 and rsp_instr_o=0x00000013.
- Flush:
  - Stimulus: request 0x0 accepted; next cycle flush_i=1 with req_valid_i=1 @0x4.
  - Required: rsp_valid_o=0 the cycle after flush, and no response for 0x4 appears.
- Collision:
  - Stimulus: mem[1]=0xAAAA_AAAA; same cycle request 0x4 and write 0xBBBB_BBBB @0x4.
  - Required: response 0xAAAAAAAA; a following request 0x4 returns 0xBBBBBBBB.
- Reset mid-operation:
  - Stimulus: response held under rsp_ready_i=0, then rst_n_i=0 for one edge.
  - Required: rsp_valid_o=0 and rsp_instr_o=0; memory contents preserved, so a re-read of 0x0 returns 0x00100093.

Source files
------------

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory for the RV32 fetch stage.
// A request is accepted on a valid/ready handshake and answered exactly one
// cycle later from a one-deep response register that holds under backpressure.
// Misaligned or out-of-range fetches return NOP_INSTR with a fault flag.
// A separate program-load port writes words; bad write addresses are dropped.
module instr_mem_sync #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 4096,
    parameter logic [31:0]        BASE_ADDR = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_instr_o,
    output logic [31:0]       rsp_addr_o,
    output logic              rsp_fault_o,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    localparam int          IDX_W      = $clog2(DEPTH);
    // Size of the mapped window in bytes; offsets at or above this fault.
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH) << 2;

    // An access is bad when it is not word aligned or falls outside the
    // window. Offsets below BASE_ADDR wrap to huge values and land here too.
    function automatic logic addr_fault(input logic [1:0]  addr_lo,
                                        input logic [31:0] off);
        return (addr_lo != 2'b00) || (off >= SPAN_BYTES);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_instr_r;
    logic [31:0]       rsp_addr_r;
    logic              rsp_fault_r;

    logic [31:0]       req_off_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic              req_fault_s;
    logic [31:0]       wr_off_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              wr_fault_s;
    logic              accept_s;

    assign req_off_s   = req_addr_i - BASE_ADDR;
    assign req_idx_s   = req_off_s[IDX_W+1:2];
    assign req_fault_s = addr_fault(req_addr_i[1:0], req_off_s);

    assign wr_off_s    = wr_addr_i - BASE_ADDR;
    assign wr_idx_s    = wr_off_s[IDX_W+1:2];
    assign wr_fault_s  = addr_fault(wr_addr_i[1:0], wr_off_s);

    // Ready depends only on the output stage, never on the incoming request
    // or on flush, so the fetch unit sees no combinational loop through us.
    assign req_ready_o = !rsp_valid_r || rsp_ready_i;
    assign accept_s    = req_valid_i && req_ready_o && !flush_i;

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_instr_o = rsp_instr_r;
    assign rsp_addr_o  = rsp_addr_r;
    assign rsp_fault_o = rsp_fault_r;

    // Program-load write port: no reset on the array, writes allowed even in reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !wr_fault_s) begin
            mem_r[wr_idx_s] <= wr_data_i;
        end
    end

    // Response stage: reset, then flush, then accept, then drain, else hold.
    // Reading mem_r here with non-blocking writes elsewhere gives read-first
    // behaviour on a same-index collision.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp_valid_r <= 1'b0;
            rsp_instr_r <= {DATA_W{1'b0}};
            rsp_addr_r  <= 32'h0000_0000;
            rsp_fault_r <= 1'b0;
        end else if (flush_i) begin
            rsp_valid_r <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_addr_r  <= req_addr_i;
            rsp_fault_r <= req_fault_s;
            rsp_instr_r <= req_fault_s ? NOP_INSTR : mem_r[req_idx_s];
        end else if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync. A second instance with BASE_ADDR at
// 0x8000_0000 shares all inputs so base-offset faults and wrap-around can be
// observed alongside the zero-based instance.
module tb_instr_mem_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic        req_ready,  req_ready_b;
    logic        rsp_valid,  rsp_valid_b;
    logic [31:0] rsp_instr,  rsp_instr_b;
    logic [31:0] rsp_addr,   rsp_addr_b;
    logic        rsp_fault,  rsp_fault_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_sync #(.DATA_W(32), .DEPTH(4096), .BASE_ADDR(32'h0000_0000),
                     .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_instr_o(rsp_instr),
        .rsp_addr_o(rsp_addr), .rsp_fault_o(rsp_fault), .flush_i(flush),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    instr_mem_sync #(.DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h8000_0000),
                     .NOP_INSTR(32'h0000_0013)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_instr_o(rsp_instr_b),
        .rsp_addr_o(rsp_addr_b), .rsp_fault_o(rsp_fault_b), .flush_i(flush),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] a, input logic f);
        check_eq({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
        check_eq({tag, ".instr"}, rsp_instr, ins);
        check_eq({tag, ".addr"},  rsp_addr,  a);
        check_eq({tag, ".fault"}, {31'd0, rsp_fault}, {31'd0, f});
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
        flush = 1'b0; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;

        // Reset; the first write lands while reset is still asserted.
        #1;
        step();
        check_rsp("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        wr_en = 1'b1; wr_addr = 32'h0000_0000; wr_data = 32'h0010_0093;
        step();
        rst_n = 1'b1;
        wr_addr = 32'h0000_0004; wr_data = 32'h0020_0113; step();
        wr_addr = 32'h0000_3FFC; wr_data = 32'h1234_5678; step();
        wr_addr = 32'h8000_0004; wr_data = 32'hCAFE_0001; step();
        // Misaligned and out-of-range writes must be dropped.
        wr_addr = 32'h0000_0005; wr_data = 32'hDEAD_BEEF; step();
        wr_addr = 32'h0000_4000; wr_data = 32'hDEAD_BEEF; step();
        wr_en = 1'b0;
        check_eq("idle.valid", {31'd0, rsp_valid}, 32'd0);

        // Load and read back, back to back.
        req_valid = 1'b1; req_addr = 32'h0000_0000; #1;
        check_eq("ready.idle", {31'd0, req_ready}, 32'd1);
        step();
        check_rsp("rd0", 1'b1, 32'h0010_0093, 32'h0000_0000, 1'b0);
        req_addr = 32'h0000_0004; step();
        check_rsp("rd4", 1'b1, 32'h0020_0113, 32'h0000_0004, 1'b0);

        // Backpressure: response for 0x4 held three cycles.
        rsp_ready = 1'b0; req_addr = 32'h0000_0000; #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp.ready", {31'd0, req_ready}, 32'd0);
            step();
            check_rsp("bp.hold", 1'b1, 32'h0020_0113, 32'h0000_0004, 1'b0);
        end
        rsp_ready = 1'b1; #1;
        check_eq("bp.release_ready", {31'd0, req_ready}, 32'd1);
        step();
        check_rsp("bp.next", 1'b1, 32'h0010_0093, 32'h0000_0000, 1'b0);

        // Last word in range, then faults.
        req_addr = 32'h0000_3FFC; step();
        check_rsp("last", 1'b1, 32'h1234_5678, 32'h0000_3FFC, 1'b0);
        req_addr = 32'h0000_0002; step();
        check_rsp("misalign", 1'b1, 32'h0000_0013, 32'h0000_0002, 1'b1);
        req_addr = 32'h0000_4000; step();
        check_rsp("range", 1'b1, 32'h0000_0013, 32'h0000_4000, 1'b1);
        // Dropped writes left mem[0] and mem[1] intact.
        req_addr = 32'h0000_0004; step();
        check_rsp("nowr5", 1'b1, 32'h0020_0113, 32'h0000_0004, 1'b0);

        // Base-offset instance: 0x0 wraps below base and faults.
        req_addr = 32'h0000_0000; step();
        check_eq("base.low_fault", {31'd0, rsp_fault_b}, 32'd1);
        check_eq("base.low_instr", rsp_instr_b, 32'h0000_0013);
        check_eq("base.main_instr", rsp_instr, 32'h0010_0093);
        req_addr = 32'h8000_0004; step();
        check_eq("base.hit_fault", {31'd0, rsp_fault_b}, 32'd0);
        check_eq("base.hit_instr", rsp_instr_b, 32'hCAFE_0001);
        check_eq("base.main_fault", {31'd0, rsp_fault}, 32'd1);

        // Drain with no request.
        req_valid = 1'b0; step();
        check_eq("drain.valid", {31'd0, rsp_valid}, 32'd0);

        // Flush: 0x0 in flight, flush while 0x4 is offered.
        req_valid = 1'b1; req_addr = 32'h0000_0000; step();
        check_eq("fl.pre", {31'd0, rsp_valid}, 32'd1);
        flush = 1'b1; req_addr = 32'h0000_0004; #1;
        check_eq("fl.ready", {31'd0, req_ready}, 32'd1);
        step();
        check_eq("fl.valid", {31'd0, rsp_valid}, 32'd0);
        flush = 1'b0; req_valid = 1'b0; step();
        check_eq("fl.no4", {31'd0, rsp_valid}, 32'd0);

        // Collision: read-first on the same index.
        wr_en = 1'b1; wr_addr = 32'h0000_0004; wr_data = 32'hAAAA_AAAA; step();
        wr_data = 32'hBBBB_BBBB; req_valid = 1'b1; req_addr = 32'h0000_0004; step();
        check_rsp("coll.old", 1'b1, 32'hAAAA_AAAA, 32'h0000_0004, 1'b0);
        wr_en = 1'b0; step();
        check_rsp("coll.new", 1'b1, 32'hBBBB_BBBB, 32'h0000_0004, 1'b0);

        // Reset mid-operation while a response is held.
        req_addr = 32'h0000_0000; step();
        rsp_ready = 1'b0; req_valid = 1'b0; step();
        check_rsp("rst.held", 1'b1, 32'h0010_0093, 32'h0000_0000, 1'b0);
        rst_n = 1'b0; step();
        check_rsp("rst.mid", 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0000; step();
        check_rsp("rst.reread", 1'b1, 32'h0010_0093, 32'h0000_0000, 1'b0);
        req_valid = 1'b0; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
